// File: rtl/middle_ram_sdp.sv
// Simple dual-port RAM between thresholding pipeline stages: one write port, one
// always-on read port, registered read data with an asynchronous clear.

module middle_ram_sdp #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q
);

  // Contents come from device configuration (zero on block RAM); reset never clears them.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] q_q;

  always_comb begin
    mem_we = wren & rst_n;
    // Sampled before this edge's write lands, so a same-address read returns old data.
    q_d    = mem[rdaddress];
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wraddress] <= data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_middle_ram_sdp.sv
// Self-checking bench for middle_ram_sdp: scoreboard of expected read data plus a
// vector table for collision and boundary cases.

module tb_middle_ram_sdp;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          rst_n;
  logic [AW-1:0] wraddress;
  logic          wren;
  logic [DW-1:0] data;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  string         name_q[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  middle_ram_sdp #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (2 ** AW)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .wraddress(wraddress),
    .wren     (wren),
    .data     (data),
    .rdaddress(rdaddress),
    .q        (q)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: q=%h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle; expected q is queued at drive time and compared after the edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic [AW-1:0] ra, input logic chk, input logic [DW-1:0] exp,
                      input string name);
    logic [DW-1:0] e;
    string         n;
    wren      = we;
    wraddress = wa;
    data      = d;
    rdaddress = ra;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clock);
    #1;
    if (chk) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, q, e);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] ev;

    vecs[0] = '{1'b1, 14'd5,     8'hAA, 14'd0,     1'b0, 8'h00};
    vecs[1] = '{1'b1, 14'd5,     8'h55, 14'd5,     1'b1, 8'hAA};
    vecs[2] = '{1'b0, 14'd0,     8'h00, 14'd5,     1'b1, 8'h55};
    vecs[3] = '{1'b1, 14'd16383, 8'h7E, 14'd0,     1'b0, 8'h00};
    vecs[4] = '{1'b1, 14'd0,     8'h11, 14'd16383, 1'b1, 8'h7E};
    vecs[5] = '{1'b0, 14'd0,     8'h00, 14'd0,     1'b1, 8'h11};
    vecs[6] = '{1'b0, 14'd0,     8'h00, 14'd16383, 1'b1, 8'h7E};
    vecs[7] = '{1'b0, 14'd0,     8'h00, 14'd1,     1'b1, 8'h01};

    rst_n     = 1'b0;
    wren      = 1'b0;
    wraddress = '0;
    data      = '0;
    rdaddress = '0;
    repeat (2) @(negedge clock);
    check("reset_q", q, 8'h00);
    rst_n = 1'b1;

    // Sequential fill then readback.
    for (int i = 0; i < 50; i++) begin
      a = AW'(i);
      step(1'b1, a, a[DW-1:0], '0, 1'b0, '0, "fill");
    end
    for (int i = 0; i < 50; i++) begin
      a = AW'(i);
      step(1'b0, '0, '0, a, 1'b1, a[DW-1:0], $sformatf("readback_%0d", i));
    end

    // Reset mid-operation: async clear, write blocked, contents preserved.
    check("pre_reset_q", q, 8'h31);
    #2 rst_n = 1'b0;
    #1 check("reset_async_clear", q, 8'h00);
    step(1'b1, 14'd49, 8'hEE, 14'd49, 1'b1, 8'h00, "reset_hold_q");
    step(1'b0, '0, '0, 14'd49, 1'b1, 8'h00, "reset_hold_q2");
    rst_n = 1'b1;
    step(1'b0, '0, '0, 14'd49, 1'b1, 8'h31, "reset_preserved_49");

    // Write disable sweep leaves prior contents intact.
    for (int i = 0; i < 10; i++) begin
      a = AW'(i);
      step(1'b0, a, 8'hFF, '0, 1'b0, '0, "wren_off");
    end
    for (int i = 0; i < 10; i++) begin
      a = AW'(i);
      step(1'b0, '0, '0, a, 1'b1, a[DW-1:0], $sformatf("wren_off_read_%0d", i));
    end

    // Collision and boundary vectors.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].d, vecs[i].ra, vecs[i].chk, vecs[i].exp,
           $sformatf("vec_%0d", i));
    end

    // Concurrent ports: write ~A to A while reading A-1.
    for (int i = 0; i <= 100; i++) begin
      a  = AW'(i);
      ev = ~DW'(i - 1);
      step(1'b1, a, ~a[DW-1:0], AW'(i - 1), (i >= 1), ev, $sformatf("concurrent_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
